// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: state encoding, cause codes
// and the fixed-priority arbiter used to pick the cause to present.
package interrupt_controller_pkg;

  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned MAX_EXT = 8;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StReq     = 2'd1;
  localparam state_t StService = 2'd2;

  localparam logic [CAUSE_W-1:0] CauseTimer   = 5'd7;
  localparam logic [CAUSE_W-1:0] CauseSw      = 5'd3;
  localparam logic [CAUSE_W-1:0] CauseExtBase = 5'd16;

  // Lowest priority is written first so higher-priority hits overwrite it.
  // Bit layout of elig: bit0 timer, bit1 sw, bit 2+i ext[i].
  function automatic logic [CAUSE_W-1:0] arb_cause(input logic [MAX_EXT+1:0] elig,
                                                    input int unsigned num_ext);
    logic [CAUSE_W-1:0] c;
    c = '0;
    if (elig[0]) c = CauseTimer;
    if (elig[1]) c = CauseSw;
    for (int i = int'(MAX_EXT) - 1; i >= 0; i--) begin
      if ((i < int'(num_ext)) && elig[2+i]) c = CauseExtBase + CAUSE_W'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous line.
// The detector stays disarmed until the pipeline holds real post-reset
// samples, so a line already high when reset releases gives no edge.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [2:0] warm_q;

  // Synchronizer, edge-detect history and post-reset arming shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 3'b000;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= {warm_q[1:0], 1'b1};
    end
  end

  assign rise_o = sync2_q & ~prev_q & warm_q[2];

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: collects timer, software and edge-triggered external
// sources, arbitrates by fixed priority and runs a request/service handshake
// with the core (IDLE -> REQ -> SERVICE -> IDLE).
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_EXT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 timer_irq,
  input  logic                 sw_irq,
  input  logic [NUM_EXT-1:0]   ext_irq,
  input  logic                 irq_enable,
  input  logic [NUM_EXT+1:0]   irq_mask,
  input  logic                 irq_ack,
  input  logic                 irq_done,
  output logic                 irq_req,
  output logic [CAUSE_W-1:0]   irq_cause,
  output logic [NUM_EXT+1:0]   irq_pending
);

  localparam int unsigned W = NUM_EXT + 2;

  logic [NUM_EXT-1:0]   ext_rise;
  logic [NUM_EXT-1:0]   ext_clr;
  logic [W-1:0]         pending_q, pending_d;
  logic [W-1:0]         eligible;
  logic [MAX_EXT+1:0]   elig_wide;
  logic                 arb_valid_q, arb_valid_d;
  logic [CAUSE_W-1:0]   arb_cause_q, arb_cause_d;
  state_t               state_q, state_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;

  for (genvar i = 0; i < int'(NUM_EXT); i++) begin : g_ext
    irq_edge_sync u_edge_sync (
      .clk    (clk),
      .reset  (reset),
      .async_i(ext_irq[i]),
      .rise_o (ext_rise[i])
    );
  end

  // Arbitration over currently eligible sources; registered before the FSM uses it
  always_comb begin
    eligible                = pending_q & irq_mask & {W{irq_enable}};
    elig_wide               = '0;
    elig_wide[W-1:0]        = eligible;
    arb_valid_d             = |eligible;
    arb_cause_d             = arb_cause(elig_wide, NUM_EXT);
  end

  // Pending update: level sources follow their inputs; ext bits latch edges,
  // clear on ack of their cause, and a simultaneous new edge wins
  always_comb begin
    for (int i = 0; i < int'(NUM_EXT); i++) begin
      ext_clr[i] = (state_q == StReq) && irq_ack && (cause_q == CauseExtBase + CAUSE_W'(i));
    end
    pending_d = {ext_rise | (pending_q[W-1:2] & ~ext_clr), sw_irq, timer_irq};
  end

  // Handshake FSM next state; cause is latched only when a request is raised
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      StIdle: begin
        if (arb_valid_q) begin
          state_d = StReq;
          cause_d = arb_cause_q;
        end
      end
      StReq: begin
        if (irq_ack) begin
          state_d = StService;
        end else if (!irq_enable) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (irq_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      arb_valid_q <= 1'b0;
      arb_cause_q <= '0;
      state_q     <= StIdle;
      cause_q     <= '0;
    end else begin
      pending_q   <= pending_d;
      arb_valid_q <= arb_valid_d;
      arb_cause_q <= arb_cause_d;
      state_q     <= state_d;
      cause_q     <= cause_d;
    end
  end

  assign irq_req     = (state_q == StReq);
  assign irq_cause   = cause_q;
  assign irq_pending = pending_q;

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_EXT, default 4, number of external interrupt lines (1..8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port timer_irq  input  1  level interrupt from the timer, synchronous to clk.
REQ-005 SHALL have port sw_irq  input  1  level software interrupt, synchronous to clk.
REQ-006 SHALL have port ext_irq  input  NUM_EXT  asynchronous external lines, rising-edge triggered.
REQ-007 SHALL have port irq_enable  input  1  global interrupt enable.
REQ-008 SHALL have port irq_mask  input  NUM_EXT+2  per-source enable: bit0 timer, bit1 sw, bits 2+ ext[i].
REQ-009 SHALL have port irq_ack  input  1  core accepts the presented request.
REQ-010 SHALL have port irq_done  input  1  core finished the handler (return-from-interrupt).
REQ-011 SHALL have port irq_req  output  1  request to the core.
REQ-012 SHALL have port irq_cause  output  5  cause code of the presented or in-service request.
REQ-013 SHALL have port irq_pending  output  NUM_EXT+2  raw pending vector, same bit layout as irq_mask.

Function
REQ-014 Each ext_irq[i] SHALL pass through a 2-flop synchronizer followed by rising-edge detection; a detected edge sets ext pending bit i on the next edge.
REQ-015 Timer and sw pending bits SHALL equal timer_irq and sw_irq registered once; no latching.
REQ-016 A source is eligible when its pending bit and mask bit are both 1 and irq_enable=1.
REQ-017 Priority SHALL be: ext[0] (highest) > ext[1] > ... > ext[NUM_EXT-1] > sw > timer.
REQ-018 Cause codes: timer=7, sw=3, ext[i]=16+i.
REQ-019 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-020 IDLE->REQ on the edge where any source is eligible; irq_cause is latched from the highest-priority eligible source on that edge.
REQ-021 REQ: irq_req=1; irq_cause SHALL be held stable, with no re-arbitration, even if a higher-priority source arrives.
REQ-022 REQ->SERVICE on irq_ack=1; the ext pending bit of the latched cause clears on the same edge. Level sources are not cleared.
REQ-023 REQ->IDLE if irq_enable=0 and irq_ack=0 (request withdrawn); irq_ack has priority when both occur.
REQ-024 In REQ, deassertion of a level source SHALL NOT withdraw the request.
REQ-025 SERVICE: irq_req=0, irq_cause held, no nesting; SERVICE->IDLE on irq_done=1.
REQ-026 irq_ack outside REQ and irq_done outside SERVICE SHALL be ignored.
REQ-027 A new edge on the same ext line in the cycle its bit is cleared by ack SHALL leave the bit set (set wins).
REQ-028 Latency, irq_enable=1 and mask set: timer_irq high before edge N gives irq_req=1 after edge N+2; an ext_irq rise sampled at edge N gives irq_req=1 after edge N+4.
REQ-029 Edges arriving in any state SHALL be latched, never lost, except for a repeat edge on an already-pending bit.

Reset
REQ-030 On reset assertion, immediately and asynchronously: state=IDLE, irq_req=0, irq_cause=0, irq_pending=0, synchronizer and edge-detect flops=0.
REQ-031 Reset during REQ or SERVICE SHALL abandon the request; no pending state survives.
REQ-032 After reset release, an ext line already held high SHALL NOT produce an edge.

Structure
REQ-033 A shared package SHALL hold the state enum, the cause-code constants, and the CAUSE_W=5 width.
REQ-034 One sub-module, irq_edge_sync (synchronizer plus rising-edge detector, 1 bit), SHALL be instantiated NUM_EXT times.

Verification
REQ-035 Timer only: mask=0x01, enable=1, timer_irq high -> irq_req high 2 cycles later with cause=7; ack -> SERVICE; done -> IDLE; re-request if timer_irq still high.
REQ-036 Priority: timer, sw and ext[2] eligible together -> cause=18; after ack/done -> cause=3 next; then cause=7.
REQ-037 Hold: in REQ with cause=7, ext[0] edge arrives -> cause stays 7 until ack; ext[0] is served next with cause=16.
REQ-038 Withdraw: in REQ, enable drops with no ack -> IDLE, irq_req=0, ext pending bit kept; enable returns -> same request reissued.
REQ-039 Set wins: ext[1] edge detected in the same cycle as ack of cause=17 -> irq_pending bit 3 stays 1.
REQ-040 Reset mid-SERVICE: outputs zero immediately; ext[0] held high across release -> no request.
